// File: rtl/mac_pkg.sv
// Shared types and width helpers for the activation MAC accumulator.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mac_state_t;

   function automatic int unsigned acc_width(input int unsigned n, input int unsigned k);
      return 2 * n + $clog2(k);
   endfunction

   function automatic int unsigned count_width(input int unsigned k);
      return $clog2(k + 1);
   endfunction

   localparam int unsigned MAC_N_DEF = 16;
   localparam int unsigned MAC_K_DEF = 4;
   localparam int unsigned MAC_CNT_W = count_width(MAC_K_DEF);

endpackage

// File: rtl/mac_product_stage.sv
// Registered signed N x N multiplier; prod_v_o marks a fresh product for the accumulator.
module mac_product_stage #(
   parameter int unsigned N = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             accept_i,
   input  logic [N-1:0]     act_i,
   input  logic [N-1:0]     weight_i,
   output logic [2*N-1:0]   prod_o,
   output logic             prod_v_o
);

   localparam int unsigned P_W = 2 * N;

   logic [P_W-1:0] prod_q, prod_d;
   logic [P_W-1:0] act_ext, weight_ext;
   logic           prod_v_q;

   // Sign-extend to 2N so the truncated unsigned product is the exact signed product.
   always_comb begin
      act_ext    = {{N{act_i[N-1]}}, act_i};
      weight_ext = {{N{weight_i[N-1]}}, weight_i};
      prod_d     = prod_q;
      if (accept_i) begin
         prod_d = act_ext * weight_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         prod_q   <= '0;
         prod_v_q <= 1'b0;
      end else begin
         prod_q   <= prod_d;
         prod_v_q <= accept_i;
      end
   end

   assign prod_o   = prod_q;
   assign prod_v_o = prod_v_q;

endmodule

// File: rtl/activation_mac_accumulator.sv
// K-beat signed MAC for one neuron with flip/patch statistics and a valid/ready result.
// Optional ReLU on the result register path when MAC_RELU_EN is defined.
module activation_mac_accumulator
   import mac_pkg::*;
#(
   parameter int unsigned N = MAC_N_DEF,
   parameter int unsigned K = MAC_K_DEF
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [N-1:0]                         act_in,
   input  logic [N-1:0]                         weight_in,
   input  logic                                 f_in,
   input  logic                                 p_in,
   input  logic                                 act_valid,
   output logic                                 act_ready,
   output logic [acc_width(N, K)-1:0]           sum_out,
   output logic [count_width(K)-1:0]            flip_count,
   output logic [count_width(K)-1:0]            patch_count,
   output logic                                 sum_valid,
   input  logic                                 sum_ready
);

   localparam int unsigned ACC_W = acc_width(N, K);
   localparam int unsigned CNT_W = (K == MAC_K_DEF) ? MAC_CNT_W : count_width(K);
   localparam int unsigned BC_W  = $clog2(K);
   localparam int unsigned P_W   = 2 * N;

   mac_state_t       state_q, state_d;
   logic             act_ready_q, act_ready_d;
   logic             sum_valid_q, sum_valid_d;
   logic [ACC_W-1:0] sum_out_q, sum_out_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] flip_q, flip_d;
   logic [CNT_W-1:0] patch_q, patch_d;
   logic [BC_W-1:0]  beat_q, beat_d;

   logic             accept_c;
   logic [P_W-1:0]   prod_c;
   logic             prod_v_c;
   logic [ACC_W-1:0] prod_ext_c;
   logic [ACC_W-1:0] result_c;

   assign accept_c   = act_valid && act_ready_q;
   assign prod_ext_c = {{(ACC_W - P_W){prod_c[P_W-1]}}, prod_c};

`ifdef MAC_RELU_EN
   assign result_c = acc_q[ACC_W-1] ? '0 : acc_q;
`else
   assign result_c = acc_q;
`endif

   mac_product_stage #(
      .N (N)
   ) u_product (
      .clk      (clk),
      .reset    (reset),
      .accept_i (accept_c),
      .act_i    (act_in),
      .weight_i (weight_in),
      .prod_o   (prod_c),
      .prod_v_o (prod_v_c)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         act_ready_q <= 1'b0;
         sum_valid_q <= 1'b0;
         sum_out_q   <= '0;
         acc_q       <= '0;
         flip_q      <= '0;
         patch_q     <= '0;
         beat_q      <= '0;
      end else begin
         state_q     <= state_d;
         act_ready_q <= act_ready_d;
         sum_valid_q <= sum_valid_d;
         sum_out_q   <= sum_out_d;
         acc_q       <= acc_d;
         flip_q      <= flip_d;
         patch_q     <= patch_d;
         beat_q      <= beat_d;
      end
   end

   // Products land one cycle after accept, so the last one is absorbed while in DRAIN.
   always_comb begin
      state_d     = state_q;
      sum_valid_d = sum_valid_q;
      sum_out_d   = sum_out_q;
      flip_d      = flip_q;
      patch_d     = patch_q;
      beat_d      = beat_q;
      acc_d       = prod_v_c ? (acc_q + prod_ext_c) : acc_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACCUM;
               acc_d   = '0;
               flip_d  = '0;
               patch_d = '0;
               beat_d  = '0;
            end
         end
         ACCUM: begin
            if (accept_c) begin
               beat_d  = beat_q + BC_W'(1);
               flip_d  = flip_q + CNT_W'(f_in);
               patch_d = patch_q + CNT_W'(p_in);
               if (beat_q == BC_W'(K - 1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            if (!sum_valid_q) begin
               sum_valid_d = 1'b1;
               sum_out_d   = result_c;
            end else if (sum_ready) begin
               sum_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      act_ready_d = (state_d == ACCUM);
   end

   assign act_ready   = act_ready_q;
   assign sum_valid   = sum_valid_q;
   assign sum_out     = sum_out_q;
   assign flip_count  = flip_q;
   assign patch_count = patch_q;

endmodule

// File: tb/tb_activation_mac_accumulator.sv
// Randomized self-checking bench for activation_mac_accumulator against a plain-arithmetic model.
module tb_activation_mac_accumulator;

   localparam int unsigned N     = 16;
   localparam int unsigned K     = 4;
   localparam int unsigned ACC_W = 34;
   localparam int unsigned CW    = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [N-1:0]     act_in;
   logic [N-1:0]     weight_in;
   logic             f_in;
   logic             p_in;
   logic             act_valid;
   logic             act_ready;
   logic [ACC_W-1:0] sum_out;
   logic [CW-1:0]    flip_count;
   logic [CW-1:0]    patch_count;
   logic             sum_valid;
   logic             sum_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic signed [N-1:0] a_v [K];
   logic signed [N-1:0] w_v [K];
   logic                f_v [K];
   logic                p_v [K];

   activation_mac_accumulator dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .act_in      (act_in),
      .weight_in   (weight_in),
      .f_in        (f_in),
      .p_in        (p_in),
      .act_valid   (act_valid),
      .act_ready   (act_ready),
      .sum_out     (sum_out),
      .flip_count  (flip_count),
      .patch_count (patch_count),
      .sum_valid   (sum_valid),
      .sum_ready   (sum_ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_beat(input int i, input logic [N-1:0] a, input logic [N-1:0] w,
                           input logic f, input logic p);
      a_v[i] = a;
      w_v[i] = w;
      f_v[i] = f;
      p_v[i] = p;
   endtask

   // Drives beats until nb are accepted; returns at the negedge after the last accepting edge.
   task automatic feed(input int nb, input int vmode, input logic [6:0] vpat, output int got);
      int j = 0;
      got = 0;
      while (got < nb && j < 200) begin
         case (vmode)
            0:       act_valid = 1'b1;
            1:       act_valid = vpat[j % 7];
            default: act_valid = 1'($urandom_range(0, 1));
         endcase
         if (act_valid) begin
            act_in    = a_v[got];
            weight_in = w_v[got];
            f_in      = f_v[got];
            p_in      = p_v[got];
         end else begin
            act_in    = N'($urandom);
            weight_in = N'($urandom);
            f_in      = 1'($urandom);
            p_in      = 1'($urandom);
         end
         if (act_valid && act_ready) got++;
         @(negedge clk);
         j++;
      end
      act_valid = 1'b0;
   endtask

   task automatic run_neuron(input int vmode, input logic [6:0] vpat, input int hold);
      longint           s = 0;
      int               fc = 0;
      int               pc = 0;
      int               got;
      int               lat = 0;
      logic [ACC_W-1:0] exp_sum;
      for (int i = 0; i < K; i++) begin
         s  += longint'(a_v[i]) * longint'(w_v[i]);
         fc += int'(f_v[i]);
         pc += int'(p_v[i]);
      end
      exp_sum = ACC_W'(s);
`ifdef MAC_RELU_EN
      if (s < 0) exp_sum = '0;
`endif
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("ready_in_accum", 64'(act_ready), 64'd1);
      feed(K, vmode, vpat, got);
      check_eq("beats_accepted", 64'(got), 64'(K));
      while (!sum_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_eq("latency", 64'(lat), 64'd2);
      check_eq("ready_low_done", 64'(act_ready), 64'd0);
      check_eq("sum_out", 64'(sum_out), 64'(exp_sum));
      check_eq("flip_count", 64'(flip_count), 64'(fc));
      check_eq("patch_count", 64'(patch_count), 64'(pc));
      sum_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         act_valid = 1'b1;
         act_in    = N'($urandom);
         weight_in = N'($urandom);
         f_in      = 1'b1;
         p_in      = 1'b1;
         @(negedge clk);
         check_eq("hold_valid", 64'(sum_valid), 64'd1);
         check_eq("hold_sum", 64'(sum_out), 64'(exp_sum));
         check_eq("hold_flip", 64'(flip_count), 64'(fc));
      end
      act_valid = 1'b0;
      sum_ready = 1'b1;
      @(negedge clk);
      sum_ready = 1'b0;
      check_eq("handshake_drop", 64'(sum_valid), 64'd0);
      check_eq("sum_after_hs", 64'(sum_out), 64'(exp_sum));
   endtask

   initial begin
      int got;
      reset     = 1'b0;
      start     = 1'b0;
      act_in    = '0;
      weight_in = '0;
      f_in      = 1'b0;
      p_in      = 1'b0;
      act_valid = 1'b0;
      sum_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("rst_sum", 64'(sum_out), 64'd0);
      check_eq("rst_valid", 64'(sum_valid), 64'd0);
      check_eq("rst_ready", 64'(act_ready), 64'd0);
      check_eq("rst_counts", 64'({flip_count, patch_count}), 64'd0);

      // act_valid in IDLE must not be consumed
      act_valid = 1'b1;
      @(negedge clk);
      check_eq("idle_ready", 64'(act_ready), 64'd0);
      act_valid = 1'b0;

      for (int i = 0; i < K; i++) set_beat(i, N'(i + 1), 16'd2, 1'b0, 1'b0);
      run_neuron(0, 7'h7f, 0);

      set_beat(0, 16'hFFFD, 16'd5,    1'b0, 1'b0);
      set_beat(1, 16'd7,    16'hFFFF, 1'b0, 1'b0);
      set_beat(2, 16'h8000, 16'h8000, 1'b0, 1'b0);
      set_beat(3, 16'd1,    16'd0,    1'b0, 1'b0);
      run_neuron(0, 7'h7f, 1);

      set_beat(0, 16'd10, 16'd3, 1'b1, 1'b0);
      set_beat(1, 16'd20, 16'd3, 1'b0, 1'b1);
      set_beat(2, 16'd30, 16'd3, 1'b1, 1'b1);
      set_beat(3, 16'd40, 16'd3, 1'b1, 1'b0);
      run_neuron(0, 7'h7f, 0);

      run_neuron(1, 7'b1011001, 5);

      // reset in the middle of a neuron, then a clean neuron
      for (int i = 0; i < K; i++) set_beat(i, 16'd100, 16'd100, 1'b1, 1'b1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      feed(2, 0, 7'h7f, got);
      reset = 1'b0;
      @(negedge clk);
      check_eq("midrst_sum", 64'(sum_out), 64'd0);
      check_eq("midrst_valid", 64'(sum_valid), 64'd0);
      check_eq("midrst_ready", 64'(act_ready), 64'd0);
      check_eq("midrst_counts", 64'({flip_count, patch_count}), 64'd0);
      reset = 1'b1;
      for (int i = 0; i < K; i++) set_beat(i, 16'd1, 16'd1, 1'b0, 1'b0);
      run_neuron(0, 7'h7f, 0);

      for (int i = 0; i < K; i++) set_beat(i, 16'hFFFF, 16'd1, 1'b0, 1'b0);
      run_neuron(2, 7'h00, 2);

      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < K; i++) begin
            set_beat(i, N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) a_v[i] = 16'h8000;
            if ($urandom_range(0, 3) == 0) w_v[i] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
         end
         run_neuron(int'($urandom_range(0, 2)), 7'($urandom), int'($urandom_range(0, 4)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
